// File: rtl/perip_sram_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : perip_sram_pkg
//  Description : Shared constants for the asynchronous SRAM controller:
//                FSM state encoding and SRAM pin polarity.
//  Revision    : 1.0 - initial release
// ============================================================================
package perip_sram_pkg;

    // FSM state encoding
    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_SETUP  = 2'd1;
    localparam logic [1:0] c_ST_ACCESS = 2'd2;
    localparam logic [1:0] c_ST_HOLD   = 2'd3;

    // All SRAM control pins are active-low
    localparam logic c_PIN_ON  = 1'b0;
    localparam logic c_PIN_OFF = 1'b1;

    // Map a logical "asserted" flag onto the physical pin level
    function automatic logic pin_drive(input logic active);
        return active ? c_PIN_ON : c_PIN_OFF;
    endfunction

endpackage
`default_nettype wire

// File: rtl/perip_sram_ctrl_reg.sv
`default_nettype none
// ============================================================================
//  Module      : perip_sram_ctrl_reg
//  Description : Basic rising-edge register with synchronous active-high
//                reset to a parameterised value and a load enable. Used for
//                every pin and data register of the SRAM controller.
//  Revision    : 1.0 - initial release
// ============================================================================
module perip_sram_ctrl_reg #(
    parameter int               WIDTH   = 1,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    // Reset has priority; otherwise load when enabled
    always_ff @(posedge clk) begin
        if (rst) begin
            o_q <= RST_VAL;
        end else if (i_en) begin
            o_q <= i_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/perip_sram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : perip_sram_ctrl
//  Description : Asynchronous SRAM controller. Each beat runs
//                SETUP -> ACCESS (WAIT_CYC cycles) -> HOLD; read requests may
//                burst over consecutive word addresses. All SRAM pins are
//                registered, so their next values are derived from the
//                next FSM state.
//  Revision    : 1.0 - initial release
// ============================================================================
module perip_sram_ctrl
    import perip_sram_pkg::*;
#(
    parameter int ADDRW    = 20,
    parameter int DATAW    = 16,
    parameter int WAIT_CYC = 2,
    parameter int LENW     = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [ADDRW-1:0]   req_addr,
    input  logic [DATAW-1:0]   req_wdata,
    input  logic [DATAW/8-1:0] req_be,
    input  logic [LENW-1:0]    req_len,
    output logic               rsp_valid,
    output logic               rsp_we,
    output logic [DATAW-1:0]   rsp_rdata,
    output logic               SRAM_CS_Pin,
    output logic               SRAM_OE_Pin,
    output logic               SRAM_WR_Pin,
    output logic [DATAW/8-1:0] SRAM_BE_Pin,
    output logic [ADDRW-1:0]   SRAM_ADDR_Pin,
    output logic [DATAW-1:0]   SRAM_DATA_IN_Pin,
    output logic               SRAM_DATA_OE_Pin,
    input  logic [DATAW-1:0]   SRAM_DATA_OUT_Pin
);

    localparam int              c_BEW      = DATAW / 8;
    localparam logic [3:0]      c_WAIT_LD  = 4'(WAIT_CYC - 1);
    localparam logic [ADDRW-1:0] c_ADDR_ONE = ADDRW'(1);
    localparam logic [LENW-1:0] c_LEN_ONE  = LENW'(1);

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [3:0]       r_cnt;
    logic [LENW-1:0]  r_beats;

    logic             r_we;
    logic [c_BEW-1:0] r_be;

    logic             w_accept;
    logic             w_we;
    logic [c_BEW-1:0] w_be;
    logic             w_last_acc;
    logic             w_more;
    logic             w_next_beat;
    logic             w_busy_nxt;
    logic             w_acc_nxt;

    logic             w_cs_d;
    logic             w_oe_d;
    logic             w_wr_d;
    logic [c_BEW-1:0] w_be_d;
    logic [ADDRW-1:0] w_addr_d;
    logic             w_doe_d;

    // Handshake: only IDLE accepts, and never while reset is asserted
    assign req_ready   = (r_state == c_ST_IDLE) && !RST;
    assign w_accept    = req_valid && req_ready;

    // On the accepting cycle the request fields are not latched yet
    assign w_we        = w_accept ? req_we : r_we;
    assign w_be        = w_accept ? req_be : r_be;

    assign w_last_acc  = (r_state == c_ST_ACCESS) && (r_cnt == 4'd0);
    assign w_more      = (r_beats != '0);
    assign w_next_beat = (r_state == c_ST_HOLD) && w_more;

    assign rsp_valid   = (r_state == c_ST_HOLD);
    assign rsp_we      = r_we;

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:   if (w_accept) w_state_nxt = c_ST_SETUP;
            c_ST_SETUP:  w_state_nxt = c_ST_ACCESS;
            c_ST_ACCESS: if (r_cnt == 4'd0) w_state_nxt = c_ST_HOLD;
            c_ST_HOLD:   w_state_nxt = w_more ? c_ST_SETUP : c_ST_IDLE;
            default:     w_state_nxt = c_ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Strobe-length down-counter, loaded while in SETUP
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt <= 4'd0;
        end else if (r_state == c_ST_SETUP) begin
            r_cnt <= c_WAIT_LD;
        end else if ((r_state == c_ST_ACCESS) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Remaining burst beats; writes are always a single beat
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_beats <= '0;
        end else if (w_accept) begin
            r_beats <= req_we ? '0 : req_len;
        end else if (w_next_beat) begin
            r_beats <= r_beats - c_LEN_ONE;
        end
    end

    // Pin next values, all derived from the upcoming state
    assign w_busy_nxt = (w_state_nxt != c_ST_IDLE);
    assign w_acc_nxt  = (w_state_nxt == c_ST_ACCESS);
    assign w_cs_d     = pin_drive(w_busy_nxt);
    assign w_oe_d     = pin_drive(w_acc_nxt && !w_we);
    assign w_wr_d     = pin_drive(w_acc_nxt && w_we);
    assign w_be_d     = !w_busy_nxt ? {c_BEW{c_PIN_OFF}}
                      : (w_we ? ~w_be : {c_BEW{c_PIN_ON}});
    assign w_doe_d    = w_busy_nxt && w_we;
    assign w_addr_d   = w_accept ? req_addr : (SRAM_ADDR_Pin + c_ADDR_ONE);

    perip_sram_ctrl_reg #(.WIDTH(1), .RST_VAL(1'b0)) u_we_lat (
        .clk(CLK), .rst(RST), .i_en(w_accept), .i_d(req_we), .o_q(r_we));

    perip_sram_ctrl_reg #(.WIDTH(c_BEW), .RST_VAL('0)) u_be_lat (
        .clk(CLK), .rst(RST), .i_en(w_accept), .i_d(req_be), .o_q(r_be));

    perip_sram_ctrl_reg #(.WIDTH(1), .RST_VAL(c_PIN_OFF)) u_cs_pin (
        .clk(CLK), .rst(RST), .i_en(1'b1), .i_d(w_cs_d), .o_q(SRAM_CS_Pin));

    perip_sram_ctrl_reg #(.WIDTH(1), .RST_VAL(c_PIN_OFF)) u_oe_pin (
        .clk(CLK), .rst(RST), .i_en(1'b1), .i_d(w_oe_d), .o_q(SRAM_OE_Pin));

    perip_sram_ctrl_reg #(.WIDTH(1), .RST_VAL(c_PIN_OFF)) u_wr_pin (
        .clk(CLK), .rst(RST), .i_en(1'b1), .i_d(w_wr_d), .o_q(SRAM_WR_Pin));

    perip_sram_ctrl_reg #(.WIDTH(c_BEW), .RST_VAL({c_BEW{c_PIN_OFF}})) u_be_pin (
        .clk(CLK), .rst(RST), .i_en(1'b1), .i_d(w_be_d), .o_q(SRAM_BE_Pin));

    perip_sram_ctrl_reg #(.WIDTH(1), .RST_VAL(1'b0)) u_doe_pin (
        .clk(CLK), .rst(RST), .i_en(1'b1), .i_d(w_doe_d), .o_q(SRAM_DATA_OE_Pin));

    // Address: loaded on accept, incremented (wrapping) between burst beats
    perip_sram_ctrl_reg #(.WIDTH(ADDRW), .RST_VAL('0)) u_addr_pin (
        .clk(CLK), .rst(RST), .i_en(w_accept || w_next_beat), .i_d(w_addr_d),
        .o_q(SRAM_ADDR_Pin));

    perip_sram_ctrl_reg #(.WIDTH(DATAW), .RST_VAL('0)) u_din_pin (
        .clk(CLK), .rst(RST), .i_en(w_accept && req_we), .i_d(req_wdata),
        .o_q(SRAM_DATA_IN_Pin));

    // Read data captured at the end of the strobe; write beats leave it alone
    perip_sram_ctrl_reg #(.WIDTH(DATAW), .RST_VAL('0)) u_rdata (
        .clk(CLK), .rst(RST), .i_en(w_last_acc && !r_we), .i_d(SRAM_DATA_OUT_Pin),
        .o_q(rsp_rdata));

endmodule
`default_nettype wire

// File: tb/tb_perip_sram_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_perip_sram_ctrl
//  Description : Self-checking bench for perip_sram_ctrl: directed vector
//                table, back-to-back and reset-abort sequences, then random
//                requests against a word-level memory reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_perip_sram_ctrl;

    localparam int ADDRW    = 20;
    localparam int DATAW    = 16;
    localparam int WAIT_CYC = 2;
    localparam int LENW     = 4;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [19:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic [1:0]  req_be = '0;
    logic [3:0]  req_len = '0;
    logic        rsp_valid;
    logic        rsp_we;
    logic [15:0] rsp_rdata;
    logic        SRAM_CS_Pin;
    logic        SRAM_OE_Pin;
    logic        SRAM_WR_Pin;
    logic [1:0]  SRAM_BE_Pin;
    logic [19:0] SRAM_ADDR_Pin;
    logic [15:0] SRAM_DATA_IN_Pin;
    logic        SRAM_DATA_OE_Pin;
    logic [15:0] SRAM_DATA_OUT_Pin = 16'hDEAD;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;
    logic [15:0] last_rdata = '0;

    perip_sram_ctrl #(
        .ADDRW(ADDRW), .DATAW(DATAW), .WAIT_CYC(WAIT_CYC), .LENW(LENW)
    ) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .req_len(req_len),
        .rsp_valid(rsp_valid), .rsp_we(rsp_we), .rsp_rdata(rsp_rdata),
        .SRAM_CS_Pin(SRAM_CS_Pin), .SRAM_OE_Pin(SRAM_OE_Pin),
        .SRAM_WR_Pin(SRAM_WR_Pin), .SRAM_BE_Pin(SRAM_BE_Pin),
        .SRAM_ADDR_Pin(SRAM_ADDR_Pin), .SRAM_DATA_IN_Pin(SRAM_DATA_IN_Pin),
        .SRAM_DATA_OE_Pin(SRAM_DATA_OE_Pin), .SRAM_DATA_OUT_Pin(SRAM_DATA_OUT_Pin)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    // ---------------- SRAM device model ----------------
    // Background pattern for never-written words
    function automatic logic [15:0] bg(input logic [19:0] a);
        return a[15:0] ^ 16'hA5C3;
    endfunction

    // Storage covers word 0..63 and 0xFFFC0..0xFFFFF
    function automatic logic [6:0] sidx(input logic [19:0] a);
        return {a[19], a[5:0]};
    endfunction

    function automatic logic [15:0] init_word(input int i);
        logic [6:0]  iv;
        logic [19:0] a;
        iv = 7'(i);
        a  = iv[6] ? {14'h3FFF, iv[5:0]} : {14'h0000, iv[5:0]};
        return (a == 20'h00010) ? 16'hBEEF : bg(a);
    endfunction

    function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] nw,
                                          input logic [1:0] be_n);
        logic [15:0] r;
        r = old;
        if (!be_n[0]) r[7:0]  = nw[7:0];
        if (!be_n[1]) r[15:8] = nw[15:8];
        return r;
    endfunction

    logic [15:0] sram_mem [128];
    bit          mem_ready = 1'b0;
    int          oe_run = 0;

    always @(posedge CLK) begin
        if (!mem_ready) begin
            for (int i = 0; i < 128; i++) sram_mem[i] <= init_word(i);
            mem_ready <= 1'b1;
        end else if (!SRAM_CS_Pin && !SRAM_WR_Pin) begin
            sram_mem[sidx(SRAM_ADDR_Pin)] <= merge(sram_mem[sidx(SRAM_ADDR_Pin)],
                                                   SRAM_DATA_IN_Pin, SRAM_BE_Pin);
        end
    end

    // Read data only becomes valid once OE has been low for WAIT_CYC cycles
    always @(negedge CLK) begin
        if (!SRAM_CS_Pin && !SRAM_OE_Pin) begin
            oe_run <= oe_run + 1;
            SRAM_DATA_OUT_Pin <= (oe_run + 1 >= WAIT_CYC) ? sram_mem[sidx(SRAM_ADDR_Pin)]
                                                          : 16'hDEAD;
        end else begin
            oe_run <= 0;
            SRAM_DATA_OUT_Pin <= 16'hDEAD;
        end
    end

    // ---------------- Reference model ----------------
    logic [15:0] ref_mem [logic [19:0]];

    function automatic logic [15:0] ref_read(input logic [19:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return bg(a);
    endfunction

    task automatic ref_write(input logic [19:0] a, input logic [15:0] d, input logic [1:0] be);
        logic [15:0] w;
        w = ref_read(a);
        if (be[0]) w[7:0]  = d[7:0];
        if (be[1]) w[15:8] = d[15:8];
        ref_mem[a] = w;
    endtask

    // ---------------- Checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Advance to the next sampling point; OE and DATA_OE must never overlap
    task automatic tick();
        @(negedge CLK);
        chk("oe_doe_overlap", (!SRAM_OE_Pin && SRAM_DATA_OE_Pin), 0);
    endtask

    task automatic issue(input logic we, input logic [19:0] a, input logic [15:0] wd,
                         input logic [1:0] be, input logic [3:0] len, output int t_acc);
        int n;
        n = 0;
        req_we = we; req_addr = a; req_wdata = wd; req_be = be; req_len = len;
        req_valid = 1'b1;
        while (!req_ready && n < 40) begin
            tick();
            n++;
        end
        chk("accept_seen", req_ready, 1);
        t_acc = cyc;
    endtask

    task automatic run_beats(input logic we, input logic [19:0] a, input logic [15:0] wd,
                             input logic [1:0] be, input logic [3:0] len, input int t_acc,
                             input bit keep, input bit chk_first, input logic [15:0] exp0);
        int          nb, t_prev, oe_n, wr_n, doe_n, n;
        logic [19:0] ad, a_seen;
        logic [1:0]  be_seen, be_exp;
        logic [15:0] exp;
        bit          got;
        nb     = we ? 1 : int'(len) + 1;
        t_prev = t_acc;
        ad     = a;
        be_exp = we ? ~be : 2'b00;
        for (int b = 0; b < nb; b++) begin
            oe_n = 0; wr_n = 0; doe_n = 0; n = 0; got = 1'b0;
            a_seen = '0; be_seen = 2'b11;
            while (!got && n < 40) begin
                tick();
                n++;
                if (b == 0 && n == 1 && !keep) req_valid = 1'b0;
                chk("ready_while_busy", req_ready, 0);
                if (!SRAM_OE_Pin) begin oe_n++; a_seen = SRAM_ADDR_Pin; be_seen = SRAM_BE_Pin; end
                if (!SRAM_WR_Pin) begin wr_n++; a_seen = SRAM_ADDR_Pin; be_seen = SRAM_BE_Pin; end
                if (SRAM_DATA_OE_Pin) doe_n++;
                got = rsp_valid;
            end
            chk("beat_seen", got, 1);
            if (got) begin
                chk("latency", cyc, t_prev + 2 + WAIT_CYC);
                t_prev = cyc;
                chk(we ? "wr_strobe_cycles" : "oe_strobe_cycles", we ? wr_n : oe_n, WAIT_CYC);
                chk("other_strobe", we ? oe_n : wr_n, 0);
                chk("addr", a_seen, ad);
                chk("be_pins", be_seen, be_exp);
                chk("data_oe_cycles", doe_n, we ? WAIT_CYC + 2 : 0);
                chk("hold_cs", SRAM_CS_Pin, 0);
                chk("rsp_we", rsp_we, we);
                if (we) begin
                    chk("rdata_kept", rsp_rdata, last_rdata);
                    chk("data_in", SRAM_DATA_IN_Pin, wd);
                    ref_write(ad, wd, be);
                end else begin
                    exp = ref_read(ad);
                    if (b == 0 && chk_first) chk("table_rdata", rsp_rdata, exp0);
                    chk("rdata", rsp_rdata, exp);
                    last_rdata = exp;
                end
            end
            ad = ad + 20'd1;
        end
        tick();
        chk("ready_back", req_ready, 1);
        chk("no_extra_rsp", rsp_valid, 0);
        chk("cs_idle", SRAM_CS_Pin, 1);
        chk("doe_idle", SRAM_DATA_OE_Pin, 0);
    endtask

    typedef struct {
        logic        we;
        logic [19:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        logic [3:0]  len;
        bit          chk0;
        logic [15:0] exp0;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int          t1, t2, n;
        logic [19:0] ra;
        logic [15:0] rwd;
        logic        rwe;
        logic [1:0]  rbe;
        logic [3:0]  rlen;

        ref_mem[20'h00010] = 16'hBEEF;
        vecs[0] = '{1'b0, 20'h00010, 16'h0000, 2'b11, 4'd0, 1'b1, 16'hBEEF};
        vecs[1] = '{1'b1, 20'h00020, 16'h1234, 2'b01, 4'd0, 1'b0, 16'h0000};
        vecs[2] = '{1'b0, 20'h00020, 16'h0000, 2'b00, 4'd0, 1'b1, 16'hA534};
        vecs[3] = '{1'b0, 20'hFFFFE, 16'h0000, 2'b01, 4'd3, 1'b1, 16'h5A3D};
        vecs[4] = '{1'b1, 20'h00021, 16'hABCD, 2'b11, 4'd0, 1'b0, 16'h0000};
        vecs[5] = '{1'b0, 20'h00021, 16'h0000, 2'b10, 4'd0, 1'b1, 16'hABCD};
        vecs[6] = '{1'b1, 20'h00022, 16'h5678, 2'b10, 4'd0, 1'b0, 16'h0000};
        vecs[7] = '{1'b0, 20'h00022, 16'h0000, 2'b11, 4'd0, 1'b1, 16'h56E1};
        vecs[8] = '{1'b1, 20'h00023, 16'h0F0F, 2'b11, 4'hF, 1'b0, 16'h0000};
        vecs[9] = '{1'b0, 20'h00023, 16'h0000, 2'b11, 4'd0, 1'b1, 16'h0F0F};

        // Reset values
        repeat (3) tick();
        chk("rst_cs", SRAM_CS_Pin, 1);
        chk("rst_oe", SRAM_OE_Pin, 1);
        chk("rst_wr", SRAM_WR_Pin, 1);
        chk("rst_be", SRAM_BE_Pin, 2'b11);
        chk("rst_doe", SRAM_DATA_OE_Pin, 0);
        chk("rst_addr", SRAM_ADDR_Pin, 0);
        chk("rst_din", SRAM_DATA_IN_Pin, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_ready", req_ready, 0);
        RST = 1'b0;
        tick();
        chk("ready_after_rst", req_ready, 1);

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].len, t1);
            run_beats(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be, vecs[i].len,
                      t1, 1'b0, vecs[i].chk0, vecs[i].exp0);
        end

        // Back-to-back with req_valid held high
        issue(1'b0, 20'h00005, 16'h0000, 2'b11, 4'd0, t1);
        run_beats(1'b0, 20'h00005, 16'h0000, 2'b11, 4'd0, t1, 1'b1, 1'b0, 16'h0000);
        issue(1'b1, 20'h00006, 16'hC0DE, 2'b11, 4'd0, t2);
        chk("b2b_accept_cycle", t2, t1 + 3 + WAIT_CYC);
        run_beats(1'b1, 20'h00006, 16'hC0DE, 2'b11, 4'd0, t2, 1'b0, 1'b0, 16'h0000);

        // Reset during the ACCESS phase of a write (data equals current contents)
        issue(1'b1, 20'h0003F, ref_read(20'h0003F), 2'b11, 4'd0, t1);
        n = 0;
        do begin
            tick();
            n++;
            req_valid = 1'b0;
        end while (SRAM_WR_Pin && n < 10);
        chk("abort_in_access", SRAM_WR_Pin, 0);
        RST = 1'b1;
        tick();
        chk("abort_wr", SRAM_WR_Pin, 1);
        chk("abort_cs", SRAM_CS_Pin, 1);
        chk("abort_doe", SRAM_DATA_OE_Pin, 0);
        chk("abort_rsp", rsp_valid, 0);
        chk("abort_ready_in_rst", req_ready, 0);
        chk("abort_rdata", rsp_rdata, 0);
        last_rdata = '0;
        RST = 1'b0;
        tick();
        chk("abort_ready_after", req_ready, 1);
        repeat (6) begin
            tick();
            chk("abort_no_rsp", rsp_valid, 0);
        end

        // Randomised requests against the reference model
        for (int k = 0; k < 40; k++) begin
            rwe  = 1'($urandom_range(0, 1));
            ra   = ($urandom_range(0, 3) == 0) ? (20'hFFFC0 + 20'($urandom_range(0, 63)))
                                               : 20'($urandom_range(0, 60));
            rwd  = 16'($urandom);
            rbe  = 2'($urandom_range(0, 3));
            rlen = rwe ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
            issue(rwe, ra, rwd, rbe, rlen, t1);
            run_beats(rwe, ra, rwd, rbe, rlen, t1, 1'b0, 1'b0, 16'h0000);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
